// File: rtl/snake_pkg.sv
// snake_pkg: shared encodings for the snake step controller.
//   dir_e   - committed heading codes (UP=00, DOWN=01, RIGHT=10, LEFT=11)
//   state_e - controller state codes (IDLE=00, RUN=01, PAUSE=10, OVER=11)
//   opposite() - reverse heading; the codes pair up on bit 0 within each axis
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_RIGHT = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } state_e;

    function automatic dir_e opposite(input dir_e d);
        return dir_e'({d[1], ~d[0]});
    endfunction

endpackage

// File: rtl/snake_step_ctrl_if.sv
// snake_step_ctrl_if: button/event inputs and step/heading outputs of the
// snake step controller.
//   master - the game side: drives buttons and events, observes outputs
//   slave  - the controller itself
interface snake_step_ctrl_if;
    logic       up;
    logic       down;
    logic       right;
    logic       left;
    logic       start;
    logic       pause;
    logic       collision;
    logic       grow;
    logic [1:0] direction;
    logic       step;
    logic [1:0] state;
    logic       turn_drop;

    modport master (
        output up, down, right, left, start, pause, collision, grow,
        input  direction, step, state, turn_drop
    );

    modport slave (
        input  up, down, right, left, start, pause, collision, grow,
        output direction, step, state, turn_drop
    );
endinterface

// File: rtl/snake_step_ctrl_turn_fifo.sv
// turn_fifo: 2-entry x 2-bit queue of pending turns.
//   clk, rst         - clock, synchronous active-high reset
//   push_i, din_i    - append a turn (caller guarantees a free slot or a pop)
//   pop_i            - drop the head (caller guarantees non-empty)
//   flush_i          - empty the queue; wins over push/pop
//   head_o, tail_o   - oldest / newest entry
//   count_o          - number of valid entries (0..2)
module turn_fifo
    import snake_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic       flush_i,
    input  dir_e       din_i,
    output dir_e       head_o,
    output dir_e       tail_o,
    output logic [1:0] count_o
);
    dir_e       mem_q [2];
    dir_e       mem_d [2];
    logic [1:0] count_q, count_d;

    // Entry 0 is always the head; a pop shifts entry 1 down.
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    mem_d[count_q[0]] = din_i;
                    count_d           = count_q + 2'd1;
                end
                2'b01: begin
                    mem_d[0] = mem_q[1];
                    count_d  = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        mem_d[0] = mem_q[1];
                        mem_d[1] = din_i;
                    end else begin
                        mem_d[0] = din_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= DIR_RIGHT;
            mem_q[1] <= DIR_RIGHT;
            count_q  <= 2'd0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[0];
    assign tail_o  = (count_q == 2'd2) ? mem_q[1] : mem_q[0];
    assign count_o = count_q;
endmodule

// File: rtl/snake_step_ctrl.sv
// snake_step_ctrl: game state machine, move-step timer and buffered turn
// handling for a snake game.
//   clk, rst - clock, synchronous active-high reset
//   bus      - snake_step_ctrl_if.slave: buttons up/down/right/left (levels),
//              start/pause/collision/grow (pulses); direction, step, state,
//              turn_drop outputs
// Parameters: TICK_DIV (base step period), MIN_DIV (fastest period),
// SPEED_STEP (period decrement per grow).
// Build option: SNAKE_SPEEDUP_EN enables grow-driven speed-up; without it the
// step period is fixed at TICK_DIV and grow is ignored.
//
// state    | meaning
// ---------+--------------------------------------------
// ST_IDLE  | waiting for start, heading RIGHT, timer cleared
// ST_RUN   | timer running, steps emitted, presses accepted
// ST_PAUSE | timer held, presses ignored
// ST_OVER  | collision seen, waiting for start to return to idle
module snake_step_ctrl
    import snake_pkg::*;
#(
    parameter int TICK_DIV   = 25000000,
    parameter int MIN_DIV    = 5000000,
    parameter int SPEED_STEP = 1000000
) (
    input logic               clk,
    input logic               rst,
    snake_step_ctrl_if.slave  bus
);
    localparam int DW = $clog2(TICK_DIV + 1);

    state_e          state_q, state_d;
    dir_e            dir_q, dir_d;
    logic [3:0]      prev_q;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic            step_q, step_d;
    logic            drop_q, drop_d;
    logic [DW-1:0]   cur_div;

    logic [3:0]      btn, edges;
    logic            press_vld;
    dir_e            press_dir;
    logic            running, tc, collide, do_step, restart;
    logic            push, pop, turn_ok;
    dir_e            ref_dir, head, tail;
    logic [1:0]      count;

    assign btn   = {bus.up, bus.down, bus.right, bus.left};
    assign edges = btn & ~prev_q;

    always_comb begin
        press_vld = |edges;
        press_dir = DIR_LEFT;
        if (edges[3])      press_dir = DIR_UP;
        else if (edges[2]) press_dir = DIR_DOWN;
        else if (edges[1]) press_dir = DIR_RIGHT;
    end

    turn_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (restart),
        .din_i   (press_dir),
        .head_o  (head),
        .tail_o  (tail),
        .count_o (count)
    );

    always_comb begin
        running = (state_q == ST_RUN);
        tc      = running && (cnt_q == cur_div - DW'(1));
        collide = running && bus.collision;
        do_step = tc && !collide;
        restart = (state_q == ST_OVER) && bus.start;
        pop     = do_step && (count != 2'd0);
        // A press is judged against the last queued turn so that two quick
        // presses cannot add up to a reversal.
        ref_dir = (count != 2'd0) ? tail : dir_q;
        turn_ok = (press_dir != ref_dir) && (press_dir != opposite(ref_dir))
                  && ((count != 2'd2) || pop);
        push    = running && press_vld && turn_ok;
        drop_d  = running && press_vld && !turn_ok;
        step_d  = do_step;

        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_RUN;
            ST_RUN:   if (bus.collision) state_d = ST_OVER;
                      else if (bus.pause) state_d = ST_PAUSE;
            ST_PAUSE: if (bus.pause) state_d = ST_RUN;
            ST_OVER:  if (bus.start) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        dir_d = dir_q;
        if (restart)  dir_d = DIR_RIGHT;
        else if (pop) dir_d = head;

        cnt_d = cnt_q;
        if (state_q != ST_PAUSE) begin
            if (!running || collide || tc) cnt_d = '0;
            else                           cnt_d = cnt_q + DW'(1);
        end
    end

`ifdef SNAKE_SPEEDUP_EN
    // pend_q collects grow decrements; cur_div_q only picks it up at a wrap so
    // the interval in progress keeps its length.
    logic [DW-1:0] cur_div_q, cur_div_d, pend_q, pend_d;

    always_comb begin
        pend_d    = pend_q;
        cur_div_d = cur_div_q;
        if (restart) begin
            pend_d    = DW'(TICK_DIV);
            cur_div_d = DW'(TICK_DIV);
        end else begin
            if (running && bus.grow) begin
                if (32'(pend_q) >= 32'(MIN_DIV) + 32'(SPEED_STEP))
                    pend_d = pend_q - DW'(SPEED_STEP);
                else
                    pend_d = DW'(MIN_DIV);
            end
            if (do_step) cur_div_d = pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q    <= DW'(TICK_DIV);
            cur_div_q <= DW'(TICK_DIV);
        end else begin
            pend_q    <= pend_d;
            cur_div_q <= cur_div_d;
        end
    end

    assign cur_div = cur_div_q;
`else
    logic unused_grow;
    assign unused_grow = bus.grow;
    assign cur_div     = DW'(TICK_DIV);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_RIGHT;
            prev_q  <= 4'b0;
            cnt_q   <= '0;
            step_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            prev_q  <= btn;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.direction = dir_q;
    assign bus.step      = step_q;
    assign bus.state     = state_q;
    assign bus.turn_drop = drop_q;
endmodule

// File: tb/tb_snake_step_ctrl.sv
// Bench for snake_step_ctrl with TICK_DIV=4, MIN_DIV=2, SPEED_STEP=1.
module tb_snake_step_ctrl;
    localparam int TD = 4;
    localparam int MD = 2;
    localparam int SS = 1;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;

    snake_step_ctrl_if bus ();

    snake_step_ctrl #(.TICK_DIV(TD), .MIN_DIV(MD), .SPEED_STEP(SS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: game rules in plain integers and a queue.
    int        m_state, m_dir, m_cnt, m_div, m_pend;
    int        m_q[$];
    logic [3:0] m_prev;
    bit        m_step, m_drop;
    bit        model_on = 0;

    always @(posedge clk) begin
        logic [3:0] b, e;
        int  pd, rf;
        bit  pv, run, tc, col, stp, pop, ok;
        cyc++;
        if (rst) begin
            m_state = 0; m_dir = 2; m_cnt = 0; m_div = TD; m_pend = TD;
            m_q.delete(); m_prev = 4'b0; m_step = 0; m_drop = 0;
            model_on = 1;
        end else begin
            b = {bus.up, bus.down, bus.right, bus.left};
            e = b & ~m_prev;
            m_prev = b;
            pv = (e != 0);
            pd = e[3] ? 0 : e[2] ? 1 : e[1] ? 2 : 3;
            run = (m_state == 1);
            tc  = run && (m_cnt == m_div - 1);
            col = run && bus.collision;
            stp = tc && !col;
            pop = stp && (m_q.size() > 0);
            ok  = 0;
            m_drop = 0;
            if (run && pv) begin
                rf = (m_q.size() > 0) ? m_q[$] : m_dir;
                // codes 0/1 are the vertical axis, 2/3 horizontal
                if (pd / 2 == rf / 2)                 ok = 0;
                else if (m_q.size() == 2 && !pop)     ok = 0;
                else                                  ok = 1;
                m_drop = !ok;
            end
            if (pop) m_dir = m_q.pop_front();
            if (ok)  m_q.push_back(pd);
            if (m_state == 1)      m_cnt = (col || tc) ? 0 : m_cnt + 1;
            else if (m_state != 2) m_cnt = 0;
`ifdef SNAKE_SPEEDUP_EN
            if (run && bus.grow) m_pend = (m_pend - SS < MD) ? MD : m_pend - SS;
            if (stp) m_div = m_pend;
`endif
            case (m_state)
                0: if (bus.start) m_state = 1;
                1: if (bus.collision) m_state = 3; else if (bus.pause) m_state = 2;
                2: if (bus.pause) m_state = 1;
                default: if (bus.start) begin
                    m_state = 0; m_dir = 2; m_q.delete(); m_cnt = 0;
                    m_div = TD; m_pend = TD;
                end
            endcase
            m_step = stp;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("direction", int'(bus.direction), m_dir);
            chk("step",      int'(bus.step),      int'(m_step));
            chk("state",     int'(bus.state),     m_state);
            chk("turn_drop", int'(bus.turn_drop), int'(m_drop));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1; tick(1); bus.start = 0;
    endtask

    task automatic pulse_pause();
        bus.pause = 1; tick(1); bus.pause = 0;
    endtask

    task automatic wait_step(output int c);
        int k;
        k = 0;
        do begin
            tick(1);
            k++;
        end while (bus.step !== 1'b1 && k < 40);
        if (bus.step !== 1'b1) chk("step_timeout", 0, 1);
        c = cyc;
    endtask

    initial begin
        int c0, c1;
        int exp_per[4];
        rst = 1;
        {bus.up, bus.down, bus.right, bus.left} = 4'b0;
        {bus.start, bus.pause, bus.collision, bus.grow} = 4'b0;
        tick(3);
        chk("rst_state", int'(bus.state), 0);
        chk("rst_dir",   int'(bus.direction), 2);
        chk("rst_step",  int'(bus.step), 0);
        chk("rst_drop",  int'(bus.turn_drop), 0);
        rst = 0;
        tick(2);
        chk("idle_hold", int'(bus.state), 0);

        // start, step period
        pulse_start();
        chk("start_run", int'(bus.state), 1);
        wait_step(c0);
        chk("step_dir", int'(bus.direction), 2);
        wait_step(c1);
        chk("step_period", c1 - c0, 4);

        // reversal press rejected
        bus.left = 1; tick(1); bus.left = 0;
        chk("rev_drop", int'(bus.turn_drop), 1);
        tick(1);
        chk("rev_drop_one", int'(bus.turn_drop), 0);
        chk("rev_dir", int'(bus.direction), 2);

        // two queued turns
        wait_step(c0);
        bus.up = 1; tick(1); bus.up = 0;
        bus.left = 1; tick(1); bus.left = 0;
        wait_step(c0);
        chk("q1_dir", int'(bus.direction), 0);
        wait_step(c0);
        chk("q2_dir", int'(bus.direction), 3);

        // third press with a full queue
        wait_step(c0);
        bus.up = 1; tick(1);
        bus.right = 1; tick(1);
        bus.down = 1; tick(1);
        chk("full_drop", int'(bus.turn_drop), 1);
        {bus.up, bus.down, bus.right, bus.left} = 4'b0;
        wait_step(c0);
        chk("full_d1", int'(bus.direction), 0);
        wait_step(c0);
        chk("full_d2", int'(bus.direction), 2);
        wait_step(c0);
        chk("full_d3", int'(bus.direction), 2);

        // pause: presses ignored, no steps
        pulse_pause();
        chk("paused", int'(bus.state), 2);
        bus.up = 1; tick(1); bus.up = 0; tick(1);
        chk("pause_nodrop", int'(bus.turn_drop), 0);
        tick(6);
        pulse_pause();
        chk("resumed", int'(bus.state), 1);

        // collision on terminal count
        wait_step(c0);
        tick(3);
        bus.collision = 1; tick(1); bus.collision = 0;
        chk("col_nostep", int'(bus.step), 0);
        chk("col_over", int'(bus.state), 3);
        pulse_start();
        chk("over_idle", int'(bus.state), 0);
        chk("over_dir", int'(bus.direction), 2);

        // grow pulses
`ifdef SNAKE_SPEEDUP_EN
        exp_per = '{4, 3, 2, 2};
`else
        exp_per = '{4, 4, 4, 4};
`endif
        pulse_start();
        wait_step(c0);
        for (int i = 0; i < 4; i++) begin
            bus.grow = 1; tick(1); bus.grow = 0;
            wait_step(c1);
            chk($sformatf("grow_period%0d", i), c1 - c0, exp_per[i]);
            c0 = c1;
        end

        // reset mid-run with a press in flight
        bus.up = 1; rst = 1; tick(1); rst = 0; bus.up = 0;
        chk("midrst_state", int'(bus.state), 0);
        chk("midrst_dir",   int'(bus.direction), 2);
        chk("midrst_drop",  int'(bus.turn_drop), 0);

        // random mix checked against the model
        pulse_start();
        for (int i = 0; i < 400; i++) begin
            bus.up        = ($urandom_range(0, 3) == 0);
            bus.down      = ($urandom_range(0, 3) == 0);
            bus.right     = ($urandom_range(0, 3) == 0);
            bus.left      = ($urandom_range(0, 3) == 0);
            bus.pause     = ($urandom_range(0, 39) == 0);
            bus.collision = ($urandom_range(0, 99) == 0);
            bus.start     = ($urandom_range(0, 19) == 0);
            bus.grow      = ($urandom_range(0, 9) == 0);
            tick(1);
        end
        {bus.up, bus.down, bus.right, bus.left} = 4'b0;
        {bus.start, bus.pause, bus.collision, bus.grow} = 4'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/snake_step_ctrl.md
SNAKE_STEP_CTRL -- requirements
Module: snake_step_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000: clock cycles per move step at base speed (>=2).
REQ-002 SHALL have parameter MIN_DIV, default 5000000: lowest step period when speed-up is enabled (>=2, <=TICK_DIV).
REQ-003 SHALL have parameter SPEED_STEP, default 1000000: step-period decrement per grow event.
REQ-004 SHALL have port clk  in  1  system clock; all logic on posedge.
REQ-005 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-006 SHALL have ports up, down, right, left  in  1 each  debounced button levels.
REQ-007 SHALL have ports start, pause, collision, grow  in  1 each  single-cycle event pulses.
REQ-008 SHALL have port direction  out  2  committed heading: UP=00, DOWN=01, RIGHT=10, LEFT=11.
REQ-009 SHALL have port step  out  1  one-cycle move pulse; direction is valid in the same cycle.
REQ-010 SHALL have port state  out  2  IDLE=00, RUN=01, PAUSE=10, OVER=11.
REQ-011 SHALL have port turn_drop  out  1  one-cycle pulse for each rejected button press.

Function
REQ-012 SHALL detect button rising edges against registered previous levels; simultaneous edges resolve by priority up>down>right>left; at most one press is accepted per cycle.
REQ-013 SHALL accept presses only in RUN; presses in IDLE, PAUSE or OVER are ignored without turn_drop.
REQ-014 SHALL push an accepted press into a 2-entry turn queue.
REQ-015 SHALL check each press against a reference heading: the queue tail if the queue is non-empty, else direction.
REQ-016 SHALL reject a press that is opposite or equal to the reference, or made while the queue is full and not popping; turn_drop asserts the cycle after the press edge.
REQ-017 SHALL run a tick counter 0..cur_div-1 in RUN only; it holds in PAUSE and clears in IDLE and OVER.
REQ-018 SHALL, when the counter is at cur_div-1 in RUN, wrap it to 0; on that same clock edge step goes high for one cycle, and if the queue is non-empty its head pops into direction.
REQ-019 SHALL allow a push and a pop in the same cycle, including at count==2; the pop frees a slot, and the push must still pass the REQ-015 check.
REQ-020 SHALL implement FSM transitions: IDLE -start-> RUN; RUN -pause-> PAUSE; PAUSE -pause-> RUN; RUN -collision-> OVER; OVER -start-> IDLE; all other events are ignored.
REQ-021 SHALL give precedence to collision over pause and over a terminal count in the same cycle: state goes to OVER and no step is emitted.
REQ-022 SHALL, on entering IDLE, set direction=RIGHT, flush the queue, clear the counter and set cur_div=TICK_DIV.

Reset
REQ-023 SHALL, on rst, set state=IDLE, direction=RIGHT, step=0, turn_drop=0, queue empty, counter=0, cur_div=TICK_DIV and button-history registers=0.
REQ-024 SHALL give rst priority over every other input, including mid-step and mid-press.

Configuration
REQ-025 SHALL, with macro SNAKE_SPEEDUP_EN defined, reduce cur_div by SPEED_STEP on each grow pulse in RUN, saturating at MIN_DIV; the change takes effect after the current counter wrap.
REQ-026 SHALL, without SNAKE_SPEEDUP_EN, keep the grow port but ignore it, so cur_div stays TICK_DIV.

Structure
REQ-027 SHALL take the direction codes, state encodings and the opposite-direction function from shared package snake_pkg.
REQ-028 SHALL implement the queue as sub-module turn_fifo: 2 entries x 2 bits, push, pop, flush, head, tail, count.

Verification (TICK_DIV=4, MIN_DIV=2, SPEED_STEP=1)
REQ-029 SHALL cover: reset, then start -> state=01; step pulses every 4 cycles with direction=10.
REQ-030 SHALL cover: in RUN with direction=RIGHT, press left -> turn_drop=1 for one cycle and direction stays 10.
REQ-031 SHALL cover: press up then, within the same step interval, left -> the next step gives direction=00 and the following step gives 11.
REQ-032 SHALL cover: three valid presses within one interval -> the third gives turn_drop=1 and only two queued turns commit.
REQ-033 SHALL cover: collision in the terminal-count cycle -> no step and state=11; then start -> state=00 and direction=10.
REQ-034 SHALL cover, with SNAKE_SPEEDUP_EN: three grow pulses -> step period shrinks 4->3->2 and stays 2.
